// File: rtl/alu_pkg.sv
// Shared opcode constants and multiplier FSM state encoding for the 4-bit ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } mul_state_e;

endpackage

// File: rtl/alu_mult_seq.sv
// Sequential 4x4 shift-add multiplier: Init starts LOAD, four ITER steps, then DONE holds P.
module alu_mult_seq
  import alu_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Init,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P,
  output logic       Done
);

  mul_state_e state_q, state_d;
  logic [7:0] mcand_q, mcand_d;
  logic [3:0] mplier_q, mplier_d;
  logic [7:0] p_q, p_d;
  logic [1:0] cnt_q, cnt_d;
  logic       done_q, done_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (Init) state_d = LOAD;
      LOAD: begin
        // Operands are captured only here, so later A/B changes cannot disturb the product.
        mcand_d  = {4'b0, A};
        mplier_d = B;
        p_d      = '0;
        cnt_d    = '0;
        state_d  = ITER;
      end
      ITER: begin
        if (mplier_q[0]) p_d = p_q + mcand_q;
        mcand_d  = {mcand_q[6:0], 1'b0};
        mplier_d = {1'b0, mplier_q[3:1]};
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: if (Init) state_d = LOAD;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign P    = p_q;
  assign Done = done_q;

endmodule

// File: rtl/alu_unit.sv
// 4-bit ALU: combinational add/sub/AND, sequential multiply; Select only muxes Sal/Cout.
module alu_unit
  import alu_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Init,
  input  logic [1:0] Select,
  output logic       Cout,
  output logic       Done,
  output logic [7:0] Sal
);

  logic [4:0] sum;
  logic [4:0] diff;
  logic [7:0] prod;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  alu_mult_seq u_mult (
    .Clk  (Clk),
    .Rst  (Rst),
    .Init (Init),
    .A    (A),
    .B    (B),
    .P    (prod),
    .Done (Done)
  );

  always_comb begin
    Sal  = '0;
    Cout = 1'b0;
    case (Select)
      OP_ADD: begin
        Sal  = {3'b0, sum};
        Cout = sum[4];
      end
      OP_SUB: begin
        // diff[4] is the borrow out, which doubles as the sign of the 5-bit result.
        Sal  = {{3{diff[4]}}, diff};
        Cout = ~diff[4];
      end
      OP_MUL: Sal = prod;
      OP_AND: Sal = {4'b0, A & B};
    endcase
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed + randomized bench for alu_unit against an arithmetic reference model.
module tb_alu_unit;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       Init;
  logic [1:0] Select;
  logic       Cout;
  logic       Done;
  logic [7:0] Sal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  alu_unit dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .A      (A),
    .B      (B),
    .Init   (Init),
    .Select (Select),
    .Cout   (Cout),
    .Done   (Done),
    .Sal    (Sal)
  );

  // Reference: {Cout, Sal} from plain integer arithmetic; mul_exp is the product the model expects.
  function automatic logic [8:0] model(input logic [1:0] sel, input int a, input int b,
                                       input int mul_exp);
    int r;
    logic c;
    r = 0;
    c = 1'b0;
    case (sel)
      2'b00: begin r = a + b; c = (a + b) > 15; end
      2'b01: begin r = (a - b) & 255; c = (a >= b); end
      2'b10: r = mul_exp;
      default: r = a & b;
    endcase
    return {c, r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic [1:0] sel, input int a, input int b,
                          input int mul_exp);
    Select = sel;
    A = a[3:0];
    B = b[3:0];
    #1;
    chk(tag, {7'b0, Cout, Sal}, {7'b0, model(sel, a, b, mul_exp)});
  endtask

  // One-cycle Init, then Done must stay low for 4 edges and rise on the 5th after LOAD.
  task automatic mul_run(input int a, input int b, input bit rand_sel);
    A = a[3:0];
    B = b[3:0];
    Init = 1'b1;
    step();
    Init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rand_sel) Select = 2'($urandom_range(0, 3));
      step();
      chk("mul_busy_done", {15'b0, Done}, 16'd0);
    end
    step();
    Select = 2'b10;
    #1;
    chk("mul_done", {15'b0, Done}, 16'd1);
    chk("mul_prod", {8'b0, Sal}, 16'(a * b));
  endtask

  initial begin
    int a, b, p;
    Rst = 1'b1; A = '0; B = '0; Init = 1'b0; Select = 2'b10;
    step();
    step();
    Rst = 1'b0;
    chk("reset_sal", {8'b0, Sal}, 16'd0);
    chk("reset_done", {15'b0, Done}, 16'd0);
    chk("reset_cout", {15'b0, Cout}, 16'd0);

    // Directed combinational points
    chk_comb("add_15_14", 2'b00, 15, 14, 0);
    chk("add_15_14_lit", {7'b0, Cout, Sal}, {7'b0, 1'b1, 8'd29});
    chk_comb("add_3_4", 2'b00, 3, 4, 0);
    chk("add_3_4_lit", {7'b0, Cout, Sal}, {7'b0, 1'b0, 8'd7});
    chk_comb("sub_9_4", 2'b01, 9, 4, 0);
    chk("sub_9_4_lit", {7'b0, Cout, Sal}, {7'b0, 1'b1, 8'd5});
    chk_comb("sub_3_5", 2'b01, 3, 5, 0);
    chk("sub_3_5_lit", {7'b0, Cout, Sal}, {7'b0, 1'b0, 8'hFE});
    chk_comb("sub_7_7", 2'b01, 7, 7, 0);
    chk("sub_7_7_lit", {7'b0, Cout, Sal}, {7'b0, 1'b1, 8'h00});
    chk_comb("and_c_a", 2'b11, 12, 10, 0);
    chk("and_c_a_lit", {7'b0, Cout, Sal}, {7'b0, 1'b0, 8'd8});

    // Multiply 13*11 with exact latency, then Select switching must not disturb it
    Select = 2'b10;
    mul_run(13, 11, 1'b0);
    chk("mul_13_11_lit", {8'b0, Sal}, 16'd143);
    chk_comb("switch_add", 2'b00, 13, 11, 143);
    chk_comb("switch_back_mul", 2'b10, 13, 11, 143);
    chk("switch_done", {15'b0, Done}, 16'd1);

    // Reset mid-multiply
    A = 4'd15; B = 4'd15; Init = 1'b1;
    step();
    Init = 1'b0;
    step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("midrst_done", {15'b0, Done}, 16'd0);
    chk("midrst_sal", {8'b0, Sal}, 16'd0);
    mul_run(15, 15, 1'b0);

    // Init re-pulse and operand change while busy are ignored
    A = 4'd6; B = 4'd7; Init = 1'b1;
    step();
    Init = 1'b0;
    step();
    Init = 1'b1; A = 4'd2;
    step();
    chk("busy_done0", {15'b0, Done}, 16'd0);
    Init = 1'b0;
    step();
    chk("busy_done1", {15'b0, Done}, 16'd0);
    step();
    chk("busy_done2", {15'b0, Done}, 16'd0);
    step();
    chk("busy_done3", {15'b0, Done}, 16'd1);
    chk("busy_prod", {8'b0, Sal}, 16'd42);

    // Init held high: restarts every 6 cycles from DONE
    a = int'($urandom_range(0, 15));
    b = int'($urandom_range(0, 15));
    A = a[3:0]; B = b[3:0]; Init = 1'b1;
    step();
    chk("hold_leave_done", {15'b0, Done}, 16'd0);
    for (int i = 0; i < 4; i++) step();
    chk("hold_pre_done", {15'b0, Done}, 16'd0);
    step();
    chk("hold_done", {15'b0, Done}, 16'd1);
    chk("hold_prod", {8'b0, Sal}, 16'(a * b));
    step();
    chk("hold_restart", {15'b0, Done}, 16'd0);
    Init = 1'b0;
    // Bounded wait for the in-flight restart to finish
    begin
      int k;
      k = 0;
      while (!Done && k < 15) begin step(); k++; end
      chk("hold_finish_within_budget", {15'b0, Done}, 16'd1);
    end

    // Randomized combinational ops
    p = a * b;
    for (int i = 0; i < 60; i++) begin
      chk_comb("rand_comb", 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), p);
    end

    // Exhaustive multiply table with random Select during the run
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        mul_run(x, y, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
